// File: rtl/fork_n_pkg.sv
// Shared definitions for the fork_n_avlstrm Avalon-ST packet router:
// FSM state encoding, fan-out limit, default beat layout and a counter helper.
package fork_n_pkg;

   localparam int MAX_FORK_OUT = 8;
   localparam int DEF_DATA_W   = 512;
   localparam int DEF_EMPTY_W  = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } fork_state_e;

   // One Avalon-ST beat as held in an output slot (default widths).
   typedef struct packed {
      logic [DEF_DATA_W-1:0]  data;
      logic                   sop;
      logic                   eop;
      logic [DEF_EMPTY_W-1:0] empty;
   } fork_beat_t;

   // 32-bit wrapping increment used by all statistics counters.
   function automatic logic [31:0] cnt_inc(input logic [31:0] value);
      return value + 32'd1;
   endfunction

endpackage

// File: rtl/fork_out_slot.sv
// One-entry output register slot with valid/ready handshake.
// A load always wins over a drain in the same cycle; the payload is only
// written on load, so it stays stable while out_valid && !out_ready.
module fork_out_slot
   import fork_n_pkg::*;
#(
   parameter type beat_t = fork_beat_t
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load,
   input  beat_t beat_in,
   input  logic  out_ready,
   output logic  out_valid,
   output beat_t beat_out
);

   // Slot occupancy and payload register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         beat_out  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         beat_out  <= beat_in;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

endmodule

// File: rtl/fork_n_avlstrm.sv
// fork_n_avlstrm: routes each Avalon-ST packet to one of N_OUT outputs chosen
// by in_channel on the SOP beat. Illegal channels drop the whole packet and
// beats outside any packet are discarded as orphans.
// Optional macro FORK_N_STATS_EN builds the 32-bit statistics counters;
// without it the stats outputs are tied to zero.
module fork_n_avlstrm
   import fork_n_pkg::*;
#(
   parameter int N_OUT   = 2,
   parameter int DATA_W  = 512,
   parameter int EMPTY_W = 6,
   parameter int CH_W    = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [DATA_W-1:0]               in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_sop,
   input  logic                            in_eop,
   input  logic [EMPTY_W-1:0]              in_empty,
   input  logic [CH_W-1:0]                 in_channel,
   output logic [N_OUT-1:0][DATA_W-1:0]    out_data,
   output logic [N_OUT-1:0]                out_valid,
   input  logic [N_OUT-1:0]                out_ready,
   output logic [N_OUT-1:0]                out_sop,
   output logic [N_OUT-1:0]                out_eop,
   output logic [N_OUT-1:0][EMPTY_W-1:0]   out_empty,
   output logic [N_OUT-1:0][31:0]          stats_out_pkt,
   output logic [N_OUT-1:0][31:0]          stats_out_pkt_s,
   output logic [31:0]                     stats_drop_pkt,
   output logic [31:0]                     stats_orphan_beat
);

   localparam int SEL_W = $clog2(N_OUT);
   localparam int N_PAD = 1 << SEL_W;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
   } beat_t;

   fork_state_e       state;
   logic [SEL_W-1:0]  sel;
   logic              ready_en;
   logic              ch_legal;
   logic [SEL_W-1:0]  ch_idx;
   logic [N_PAD-1:0]  slot_free;
   logic              accept;
   logic              route_en;
   logic [SEL_W-1:0]  route_idx;
   beat_t             beat_in;
   beat_t             slot_beat [N_OUT];

   assign ch_legal = (in_channel < CH_W'(N_OUT));
   assign ch_idx   = in_channel[SEL_W-1:0];
   assign accept   = in_valid && in_ready;
   assign beat_in  = {in_data, in_sop, in_eop, in_empty};

   // A slot can take a beat when empty or draining this cycle; padded to a power of two.
   always_comb begin
      slot_free = '0;
      slot_free[N_OUT-1:0] = ~out_valid | out_ready;
   end

   // Input backpressure from FSM state and target slot only, never from in_valid.
   always_comb begin
      in_ready = 1'b0;
      if (!rst_n || !ready_en) begin
         in_ready = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_sop && ch_legal) begin
                  in_ready = slot_free[ch_idx];
               end else begin
                  in_ready = 1'b1;
               end
            end
            ST_FWD:  in_ready = slot_free[sel];
            ST_DROP: in_ready = 1'b1;
            default: in_ready = 1'b0;
         endcase
      end
   end

   // Decide which slot, if any, loads the accepted beat.
   always_comb begin
      route_en  = 1'b0;
      route_idx = sel;
      case (state)
         ST_IDLE: begin
            if (in_sop && ch_legal) begin
               route_en  = accept;
               route_idx = ch_idx;
            end else begin
               route_en  = 1'b0;
            end
         end
         ST_FWD:  route_en = accept;
         ST_DROP: route_en = 1'b0;
         default: route_en = 1'b0;
      endcase
   end

   // Packet FSM: tracks in-packet state, latched route and post-reset ready gating.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         sel      <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (accept) begin
            case (state)
               ST_IDLE: begin
                  if (in_sop && ch_legal) begin
                     sel   <= ch_idx;
                     state <= in_eop ? ST_IDLE : ST_FWD;
                  end else if (in_sop) begin
                     state <= in_eop ? ST_IDLE : ST_DROP;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_FWD:  state <= in_eop ? ST_IDLE : ST_FWD;
               ST_DROP: state <= in_eop ? ST_IDLE : ST_DROP;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   for (genvar i = 0; i < N_OUT; i++) begin : g_slot
      fork_out_slot #(
         .beat_t (beat_t)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (route_en && (route_idx == SEL_W'(i))),
         .beat_in   (beat_in),
         .out_ready (out_ready[i]),
         .out_valid (out_valid[i]),
         .beat_out  (slot_beat[i])
      );
      assign out_data[i]  = slot_beat[i].data;
      assign out_sop[i]   = slot_beat[i].sop;
      assign out_eop[i]   = slot_beat[i].eop;
      assign out_empty[i] = slot_beat[i].empty;
   end

`ifdef FORK_N_STATS_EN
   logic [N_OUT-1:0][31:0] pkt_cnt;
   logic [N_OUT-1:0][31:0] pkt_s_cnt;
   logic [31:0]            drop_cnt;
   logic [31:0]            orphan_cnt;
   logic                   drop_hit;
   logic                   orphan_hit;

   assign drop_hit   = accept && (state == ST_IDLE) && in_sop && !ch_legal;
   assign orphan_hit = accept && (state == ST_IDLE) && !in_sop;

   // Wrapping statistics; per-output counts follow output handshakes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_cnt    <= '0;
         pkt_s_cnt  <= '0;
         drop_cnt   <= 32'd0;
         orphan_cnt <= 32'd0;
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            if (out_valid[i] && out_ready[i] && out_eop[i]) begin
               pkt_cnt[i] <= cnt_inc(pkt_cnt[i]);
            end
            if (out_valid[i] && out_ready[i] && out_sop[i]) begin
               pkt_s_cnt[i] <= cnt_inc(pkt_s_cnt[i]);
            end
         end
         if (drop_hit) begin
            drop_cnt <= cnt_inc(drop_cnt);
         end
         if (orphan_hit) begin
            orphan_cnt <= cnt_inc(orphan_cnt);
         end
      end
   end

   assign stats_out_pkt     = pkt_cnt;
   assign stats_out_pkt_s   = pkt_s_cnt;
   assign stats_drop_pkt    = drop_cnt;
   assign stats_orphan_beat = orphan_cnt;
`else
   assign stats_out_pkt     = '0;
   assign stats_out_pkt_s   = '0;
   assign stats_drop_pkt    = 32'd0;
   assign stats_orphan_beat = 32'd0;
`endif

endmodule

// File: tb/tb_fork_n_avlstrm.sv
// Directed self-checking bench for fork_n_avlstrm with N_OUT = 4.
// Expected statistics follow FORK_N_STATS_EN: real counts when defined, zero otherwise.
module tb_fork_n_avlstrm;

   localparam int N_OUT   = 4;
   localparam int DATA_W  = 32;
   localparam int EMPTY_W = 2;
   localparam int CH_W    = 8;
`ifdef FORK_N_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic                           clk;
   logic                           rst_n;
   logic [DATA_W-1:0]              in_data;
   logic                           in_valid;
   logic                           in_ready;
   logic                           in_sop;
   logic                           in_eop;
   logic [EMPTY_W-1:0]             in_empty;
   logic [CH_W-1:0]                in_channel;
   logic [N_OUT-1:0][DATA_W-1:0]   out_data;
   logic [N_OUT-1:0]               out_valid;
   logic [N_OUT-1:0]               out_ready;
   logic [N_OUT-1:0]               out_sop;
   logic [N_OUT-1:0]               out_eop;
   logic [N_OUT-1:0][EMPTY_W-1:0]  out_empty;
   logic [N_OUT-1:0][31:0]         stats_out_pkt;
   logic [N_OUT-1:0][31:0]         stats_out_pkt_s;
   logic [31:0]                    stats_drop_pkt;
   logic [31:0]                    stats_orphan_beat;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int                 idx;
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
   } mon_beat_t;

   mon_beat_t mon_q [$];

   fork_n_avlstrm #(
      .N_OUT   (N_OUT),
      .DATA_W  (DATA_W),
      .EMPTY_W (EMPTY_W),
      .CH_W    (CH_W)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_sop            (in_sop),
      .in_eop            (in_eop),
      .in_empty          (in_empty),
      .in_channel        (in_channel),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_sop           (out_sop),
      .out_eop           (out_eop),
      .out_empty         (out_empty),
      .stats_out_pkt     (stats_out_pkt),
      .stats_out_pkt_s   (stats_out_pkt_s),
      .stats_drop_pkt    (stats_drop_pkt),
      .stats_orphan_beat (stats_orphan_beat)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every beat handed off on any output outside reset
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < N_OUT; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               mon_q.push_back('{i, out_data[i], out_sop[i], out_eop[i], out_empty[i]});
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_stat(input logic [31:0] n);
      return STATS_ON ? n : 32'd0;
   endfunction

   // Drive one beat from posedge+1 and hold it until accepted (bounded).
   task automatic send_beat(input string tag, input logic [DATA_W-1:0] d, input logic s,
                            input logic e, input logic [EMPTY_W-1:0] emp, input logic [CH_W-1:0] ch);
      bit done;
      done       = 1'b0;
      in_data    = d;
      in_sop     = s;
      in_eop     = e;
      in_empty   = emp;
      in_channel = ch;
      in_valid   = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            done = 1'b1;
            break;
         end
      end
      check_val({tag, "_accept"}, 64'(done), 64'd1);
      if (done) begin
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input string tag, input int idx, input logic [DATA_W-1:0] d,
                              input logic s, input logic e, input logic [EMPTY_W-1:0] emp);
      mon_beat_t b;
      check_val({tag, "_present"}, 64'(mon_q.size() > 0), 64'd1);
      if (mon_q.size() > 0) begin
         b = mon_q.pop_front();
         check_val({tag, "_idx"},   64'(b.idx), 64'(idx));
         check_val({tag, "_data"},  64'(b.data), 64'(d));
         check_val({tag, "_flags"}, {60'd0, b.sop, b.eop, b.empty}, {60'd0, s, e, emp});
      end
   endtask

   task automatic check_stats_zero(input string tag);
      for (int i = 0; i < N_OUT; i++) begin
         check_val({tag, "_pkt"},   64'(stats_out_pkt[i]),   64'd0);
         check_val({tag, "_pkt_s"}, 64'(stats_out_pkt_s[i]), 64'd0);
      end
      check_val({tag, "_drop"},   64'(stats_drop_pkt),    64'd0);
      check_val({tag, "_orphan"}, 64'(stats_orphan_beat), 64'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_data    = '0;
      in_valid   = 1'b0;
      in_sop     = 1'b0;
      in_eop     = 1'b0;
      in_empty   = '0;
      in_channel = '0;
      out_ready  = '0;

      // Reset state and post-reset ready gating
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_in_ready", 64'(in_ready), 64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_stats_zero("rst_stats");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_first_cycle_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check_val("rst_second_cycle_ready", 64'(in_ready), 64'd1);
      idle_cycles(1);

      // 3-beat packet on channel 2, all outputs ready
      out_ready = 4'hF;
      check_val("t1_pre_valid", 64'(out_valid), 64'd0);
      for (int b = 0; b < 3; b++) begin
         send_beat("t1_beat", 32'hA000_0000 + 32'(b), (b == 0), (b == 2), (b == 2) ? 2'd1 : 2'd0, 8'd2);
         check_val("t1_valid", 64'(out_valid), 64'b0100);
         check_val("t1_data", 64'(out_data[2]), 64'(32'hA000_0000 + 32'(b)));
         check_val("t1_sop", 64'(out_sop[2]), 64'(b == 0));
         check_val("t1_eop", 64'(out_eop[2]), 64'(b == 2));
      end
      idle_cycles(2);
      check_val("t1_drained", 64'(out_valid), 64'd0);
      expect_beat("t1_q0", 2, 32'hA000_0000, 1'b1, 1'b0, 2'd0);
      expect_beat("t1_q1", 2, 32'hA000_0001, 1'b0, 1'b0, 2'd0);
      expect_beat("t1_q2", 2, 32'hA000_0002, 1'b0, 1'b1, 2'd1);
      check_val("t1_others_idle", 64'(mon_q.size()), 64'd0);
      check_val("t1_pkt2", 64'(stats_out_pkt[2]), 64'(exp_stat(32'd1)));
      check_val("t1_pkt_s2", 64'(stats_out_pkt_s[2]), 64'(exp_stat(32'd1)));
      check_val("t1_pkt0", 64'(stats_out_pkt[0]), 64'd0);

      // Single-beat packet on illegal channel 5 is dropped
      send_beat("t2_beat", 32'hDEAD_0005, 1'b1, 1'b1, 2'd0, 8'd5);
      check_val("t2_no_valid", 64'(out_valid), 64'd0);
      idle_cycles(2);
      check_val("t2_no_beats", 64'(mon_q.size()), 64'd0);
      check_val("t2_drop", 64'(stats_drop_pkt), 64'(exp_stat(32'd1)));

      // Two orphan beats, then a normal packet on channel 0
      send_beat("t3_orphan_a", 32'h0000_00AA, 1'b0, 1'b0, 2'd0, 8'd0);
      send_beat("t3_orphan_b", 32'h0000_00BB, 1'b0, 1'b1, 2'd0, 8'd1);
      idle_cycles(1);
      check_val("t3_orphan", 64'(stats_orphan_beat), 64'(exp_stat(32'd2)));
      check_val("t3_no_beats", 64'(mon_q.size()), 64'd0);
      send_beat("t3_pkt_b0", 32'h3000_0000, 1'b1, 1'b0, 2'd0, 8'd0);
      send_beat("t3_pkt_b1", 32'h3000_0001, 1'b0, 1'b1, 2'd3, 8'd0);
      idle_cycles(2);
      expect_beat("t3_q0", 0, 32'h3000_0000, 1'b1, 1'b0, 2'd0);
      expect_beat("t3_q1", 0, 32'h3000_0001, 1'b0, 1'b1, 2'd3);
      check_val("t3_pkt0", 64'(stats_out_pkt[0]), 64'(exp_stat(32'd1)));

      // Backpressure on out[0] stalls the input; packet B follows on out[1]
      out_ready = 4'b1110;
      send_beat("t4_a0", 32'h4A00_0000, 1'b1, 1'b0, 2'd0, 8'd0);
      in_data    = 32'h4A00_0001;
      in_sop     = 1'b0;
      in_eop     = 1'b0;
      in_empty   = 2'd0;
      in_channel = 8'd0;
      in_valid   = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_val("t4_stall_ready", 64'(in_ready), 64'd0);
         check_val("t4_hold_valid", 64'(out_valid[0]), 64'd1);
         check_val("t4_hold_data", 64'(out_data[0]), 64'(32'h4A00_0000));
      end
      @(posedge clk);
      #1 out_ready = 4'hF;
      send_beat("t4_a1", 32'h4A00_0001, 1'b0, 1'b0, 2'd0, 8'd0);
      send_beat("t4_a2", 32'h4A00_0002, 1'b0, 1'b1, 2'd2, 8'd0);
      send_beat("t4_b0", 32'h4B00_0000, 1'b1, 1'b0, 2'd0, 8'd1);
      send_beat("t4_b1", 32'h4B00_0001, 1'b0, 1'b1, 2'd0, 8'd1);
      idle_cycles(2);
      expect_beat("t4_qa0", 0, 32'h4A00_0000, 1'b1, 1'b0, 2'd0);
      expect_beat("t4_qa1", 0, 32'h4A00_0001, 1'b0, 1'b0, 2'd0);
      expect_beat("t4_qa2", 0, 32'h4A00_0002, 1'b0, 1'b1, 2'd2);
      expect_beat("t4_qb0", 1, 32'h4B00_0000, 1'b1, 1'b0, 2'd0);
      expect_beat("t4_qb1", 1, 32'h4B00_0001, 1'b0, 1'b1, 2'd0);
      check_val("t4_pkt0", 64'(stats_out_pkt[0]), 64'(exp_stat(32'd2)));
      check_val("t4_pkt1", 64'(stats_out_pkt[1]), 64'(exp_stat(32'd1)));
      check_val("t4_pkt_s1", 64'(stats_out_pkt_s[1]), 64'(exp_stat(32'd1)));

      // Reset after beat 2 of a 5-beat packet on channel 3
      send_beat("t5_c0", 32'h5C00_0000, 1'b1, 1'b0, 2'd0, 8'd3);
      send_beat("t5_c1", 32'h5C00_0001, 1'b0, 1'b0, 2'd0, 8'd3);
      check_val("t5_held_valid", 64'(out_valid[3]), 64'd1);
      check_val("t5_held_data", 64'(out_data[3]), 64'(32'h5C00_0001));
      rst_n = 1'b0;
      @(negedge clk);
      check_val("t5_rst_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_val("t5_rst_valid", 64'(out_valid), 64'd0);
      check_stats_zero("t5_rst_stats");
      send_beat("t5_c2", 32'h5C00_0002, 1'b0, 1'b0, 2'd0, 8'd3);
      send_beat("t5_c3", 32'h5C00_0003, 1'b0, 1'b0, 2'd0, 8'd3);
      send_beat("t5_c4", 32'h5C00_0004, 1'b0, 1'b1, 2'd0, 8'd3);
      idle_cycles(2);
      expect_beat("t5_q0", 3, 32'h5C00_0000, 1'b1, 1'b0, 2'd0);
      check_val("t5_no_more_beats", 64'(mon_q.size()), 64'd0);
      check_val("t5_orphan", 64'(stats_orphan_beat), 64'(exp_stat(32'd3)));
      check_val("t5_pkt3", 64'(stats_out_pkt[3]), 64'd0);
      check_val("t5_valid_idle", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
